// File: rtl/mem_wb_forward_source.sv
// MEM and WB pipeline registers feeding Execute's forwarding muxes.
// Also formats load data, drives the register-file write port and flags load-use hazards.
module mem_wb_forward_source (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_we,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_result,
  input  logic [31:0] dmem_rdata,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  output logic [31:0] previous,
  output logic [4:0]  prev_rd,
  output logic        prev_reg_we,
  output logic [31:0] writeback,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_we,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        load_use_stall
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] res;
  } stage_t;

  stage_t      mem_q, mem_d;
  stage_t      wb_q, wb_d;
  logic        held_q, held_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_fmt;
  logic [31:0] wb_val;

  always_comb begin
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      mem_d.valid = ex_valid;
      mem_d.rd    = ex_rd;
      mem_d.we    = ex_reg_we;
      mem_d.ld    = ex_is_load;
      mem_d.f3    = ex_funct3;
      mem_d.res   = ex_result;
      wb_d        = mem_q;
    end
  end

  always_comb begin
    byte_sel = dmem_rdata[7:0];
    unique case (wb_q.res[1:0])
      2'd0: byte_sel = dmem_rdata[7:0];
      2'd1: byte_sel = dmem_rdata[15:8];
      2'd2: byte_sel = dmem_rdata[23:16];
      2'd3: byte_sel = dmem_rdata[31:24];
      default: byte_sel = dmem_rdata[7:0];
    endcase
    half_sel = wb_q.res[1] ? dmem_rdata[31:16]
                           : dmem_rdata[15:0];
    unique case (wb_q.f3)
      3'b000:  ld_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_fmt = {24'd0, byte_sel};
      3'b001:  ld_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_fmt = {16'd0, half_sel};
      default: ld_fmt = dmem_rdata;
    endcase
  end

  // Live memory data only on the first WB cycle; the hold copy after that.
  always_comb begin
    held_d = freeze;
    hold_d = held_q ? hold_q : ld_fmt;
    wb_val = wb_q.res;
    if (wb_q.ld) begin
      wb_val = held_q ? hold_q : ld_fmt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      wb_q   <= '0;
      held_q <= 1'b0;
      hold_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wb_q   <= wb_d;
      held_q <= held_d;
      hold_q <= hold_d;
    end
  end

  assign previous    = mem_q.res;
  assign prev_rd     = mem_q.rd;
  assign prev_reg_we = mem_q.valid & mem_q.we & ~mem_q.ld;

  assign writeback = wb_val;
  assign wb_rd     = wb_q.rd;
  assign wb_reg_we = wb_q.valid & wb_q.we;

  assign rf_we = wb_reg_we & (wb_q.rd != 5'd0) & ~freeze;
  assign rf_wa = wb_q.rd;
  assign rf_wd = wb_val;

  assign load_use_stall = ex_valid & ex_is_load & ex_reg_we
                        & (ex_rd != 5'd0)
                        & ((id_uses_rs1 & (id_rs1 == ex_rd))
                         | (id_uses_rs2 & (id_rs2 == ex_rd)));

endmodule

// File: tb/tb_mem_wb_forward_source.sv
// Bench for mem_wb_forward_source: instruction-level model checked every
// cycle, plus hand-computed literal expectations.
module tb_mem_wb_forward_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_result;
  logic [31:0] dmem_rdata;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [31:0] previous;
  logic [4:0]  prev_rd;
  logic        prev_reg_we;
  logic [31:0] writeback;
  logic [4:0]  wb_rd;
  logic        wb_reg_we;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        load_use_stall;

  mem_wb_forward_source dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
    .ex_funct3(ex_funct3), .ex_result(ex_result),
    .dmem_rdata(dmem_rdata),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .previous(previous), .prev_rd(prev_rd),
    .prev_reg_we(prev_reg_we), .writeback(writeback),
    .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] res;
  } ins_t;

  ins_t        m_mem;
  ins_t        m_wb;
  int          age;
  logic [31:0] first_val;

  function automatic ins_t blank();
    ins_t b;
    b.v = 1'b0; b.rd = '0; b.we = 1'b0;
    b.ld = 1'b0; b.f3 = '0; b.res = '0;
    return b;
  endfunction

  function automatic ins_t cur_ex();
    ins_t b;
    b.v = ex_valid; b.rd = ex_rd; b.we = ex_reg_we;
    b.ld = ex_is_load; b.f3 = ex_funct3; b.res = ex_result;
    return b;
  endfunction

  function automatic logic [31:0] fmt(input logic [2:0] f3,
                                      input logic [31:0] a,
                                      input logic [31:0] d);
    int off;
    logic [31:0] b;
    logic [31:0] h;
    off = int'(a % 4);
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Instructions advance one stage per unfrozen edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mem <= blank();
      m_wb  <= blank();
      age   <= 0;
    end else if (!freeze) begin
      m_wb  <= m_mem;
      m_mem <= cur_ex();
      age   <= 0;
    end else begin
      age <= age + 1;
    end
  end

  always @(negedge clk) begin
    logic e_lus;
    if (!rst) begin
      if (age == 0) first_val = fmt(m_wb.f3, m_wb.res, dmem_rdata);
      e_lus = ex_valid && ex_is_load && ex_reg_we && ex_rd != 0
           && ((id_uses_rs1 && id_rs1 == ex_rd)
            || (id_uses_rs2 && id_rs2 == ex_rd));
      chk("m_previous", previous, m_mem.res);
      chk("m_prev_rd", 32'(prev_rd), 32'(m_mem.rd));
      chk("m_prev_we", 32'(prev_reg_we),
          32'(m_mem.v && m_mem.we && !m_mem.ld));
      chk("m_writeback", writeback, m_wb.ld ? first_val : m_wb.res);
      chk("m_wb_rd", 32'(wb_rd), 32'(m_wb.rd));
      chk("m_wb_we", 32'(wb_reg_we), 32'(m_wb.v && m_wb.we));
      chk("m_rf_we", 32'(rf_we),
          32'(m_wb.v && m_wb.we && m_wb.rd != 0 && !freeze));
      chk("m_rf_wa", 32'(rf_wa), 32'(m_wb.rd));
      chk("m_rf_wd", rf_wd, m_wb.ld ? first_val : m_wb.res);
      chk("m_stall", 32'(load_use_stall), 32'(e_lus));
    end
  end

  task automatic ex_set(input logic v, input logic [4:0] rd,
                        input logic we, input logic ld,
                        input logic [2:0] f3, input logic [31:0] r);
    ex_valid = v; ex_rd = rd; ex_reg_we = we;
    ex_is_load = ld; ex_funct3 = f3; ex_result = r;
  endtask

  task automatic idle();
    ex_set(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; idle();
    id_rs1 = '0; id_rs2 = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    dmem_rdata = '0;
    @(negedge clk);
    chk("rst_previous", previous, 32'd0);
    chk("rst_writeback", writeback, 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU chain: addi x5 = 7
    ex_set(1'b1, 5'd5, 1'b1, 1'b0, 3'd0, 32'd7);
    next_cyc(); idle();
    @(negedge clk);
    chk("alu_previous", previous, 32'd7);
    chk("alu_prev_rd", 32'(prev_rd), 32'd5);
    chk("alu_prev_we", 32'(prev_reg_we), 32'd1);
    next_cyc();
    @(negedge clk);
    chk("alu_writeback", writeback, 32'd7);
    chk("alu_rf_we", 32'(rf_we), 32'd1);
    chk("alu_rf_wa", 32'(rf_wa), 32'd5);
    next_cyc();

    // LB, LBU, LH back to back at offset 2
    ex_set(1'b1, 5'd6, 1'b1, 1'b1, 3'b000, 32'h1002);
    next_cyc();
    ex_set(1'b1, 5'd6, 1'b1, 1'b1, 3'b100, 32'h1002);
    @(negedge clk);
    chk("lb_mem_we", 32'(prev_reg_we), 32'd0);
    chk("lb_mem_rd", 32'(prev_rd), 32'd6);
    next_cyc();
    ex_set(1'b1, 5'd7, 1'b1, 1'b1, 3'b001, 32'h1002);
    dmem_rdata = 32'h12F45678;
    @(negedge clk);
    chk("lb_wb", writeback, 32'hFFFFFFF4);
    next_cyc(); idle();
    @(negedge clk);
    chk("lbu_wb", writeback, 32'h000000F4);
    next_cyc();
    @(negedge clk);
    chk("lh_wb", writeback, 32'h000012F4);
    next_cyc();

    // Load-use detection
    ex_set(1'b1, 5'd3, 1'b1, 1'b1, 3'b010, 32'h40);
    id_rs2 = 5'd3; id_uses_rs2 = 1'b1;
    #1 chk("lus_hit", 32'(load_use_stall), 32'd1);
    id_uses_rs2 = 1'b0;
    #1 chk("lus_unused", 32'(load_use_stall), 32'd0);
    ex_rd = 5'd0; id_uses_rs2 = 1'b1;
    #1 chk("lus_x0", 32'(load_use_stall), 32'd0);
    next_cyc();
    id_rs2 = '0; id_uses_rs2 = 1'b0;

    // Freeze across WB of lw x4
    ex_set(1'b1, 5'd4, 1'b1, 1'b1, 3'b010, 32'h2000);
    next_cyc(); idle();
    @(negedge clk);
    chk("ldmem_prev_we", 32'(prev_reg_we), 32'd0);
    chk("ldmem_prev_rd", 32'(prev_rd), 32'd4);
    next_cyc();
    dmem_rdata = 32'hAAAA5555; freeze = 1'b1;
    @(negedge clk);
    chk("frz_first_wb", writeback, 32'hAAAA5555);
    chk("frz_first_rfwe", 32'(rf_we), 32'd0);
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      dmem_rdata = 32'hDEADBEEF;
      if (k == 0) begin
        ex_set(1'b1, 5'd2, 1'b1, 1'b1, 3'b010, 32'h0);
        id_rs1 = 5'd2; id_uses_rs1 = 1'b1;
      end else begin
        idle(); id_rs1 = '0; id_uses_rs1 = 1'b0;
      end
      @(negedge clk);
      if (k == 0) chk("frz_stall", 32'(load_use_stall), 32'd1);
      chk("frz_hold_wb", writeback, 32'hAAAA5555);
      chk("frz_hold_rfwe", 32'(rf_we), 32'd0);
    end
    next_cyc();
    freeze = 1'b0;
    @(negedge clk);
    chk("frz_release_wb", writeback, 32'hAAAA5555);
    chk("frz_release_rfwe", 32'(rf_we), 32'd1);
    chk("frz_release_wa", 32'(rf_wa), 32'd4);
    next_cyc();

    // rd = x0 propagates but never writes
    ex_set(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 32'd9);
    next_cyc(); idle();
    next_cyc();
    @(negedge clk);
    chk("x0_wb", writeback, 32'd9);
    chk("x0_wb_we", 32'(wb_reg_we), 32'd1);
    chk("x0_rf_we", 32'(rf_we), 32'd0);
    next_cyc();

    // Mixed vector table, model-checked
    for (int i = 0; i < 16; i++) begin
      ex_set(1'b1 ^ (i % 5 == 4), 5'((i * 3) % 32), 1'(i % 7 != 6),
             1'(i % 3 == 0), 3'(i % 8), 32'(i * 257 + i % 4));
      dmem_rdata = 32'h80FF7F01 ^ 32'(i * 32'h01010101);
      freeze = 1'(i % 4 == 2);
      id_rs1 = 5'((i * 3) % 32); id_uses_rs1 = 1'(i % 2);
      id_rs2 = 5'(i); id_uses_rs2 = 1'(i % 3 == 1);
      next_cyc();
    end
    freeze = 1'b0; idle();
    id_rs1 = '0; id_rs2 = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    dmem_rdata = '0;

    // Async reset with both stages full
    ex_set(1'b1, 5'd8, 1'b1, 1'b0, 3'd0, 32'd11);
    next_cyc();
    ex_set(1'b1, 5'd9, 1'b1, 1'b0, 3'd0, 32'd22);
    next_cyc(); idle();
    @(negedge clk);
    chk("full_previous", previous, 32'd22);
    chk("full_writeback", writeback, 32'd11);
    #2 rst = 1'b1;
    #1;
    chk("arst_previous", previous, 32'd0);
    chk("arst_writeback", writeback, 32'd0);
    chk("arst_prev_we", 32'(prev_reg_we), 32'd0);
    chk("arst_wb_we", 32'(wb_reg_we), 32'd0);
    chk("arst_wb_rd", 32'(wb_rd), 32'd0);
    chk("arst_rf_wd", rf_wd, 32'd0);
    chk("arst_rf_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    chk("arst_edge_rf_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("post_rst_wb", writeback, 32'd0);
    next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
